// File: rtl/ika2151_regwr_scheduler.sv
`timescale 1ns/1ps
// ika2151_regwr_scheduler
// Sits between the host bus interface and the OPM register file. Host
// address writes update an address latch. Host data writes are paired with
// that latched address and queued in a small FIFO. Once per 32-slot frame,
// on the CYCLE_31 phi1 tick, the head entry is committed to the register
// file as a one-phi1-cycle write pulse. BUSY tells the host to back off
// while writes are still settling or queued.
//
// Handshake summary:
//   Host side: i_WR_STB is a single-EMUCLK strobe with no ready/backpressure.
//   A data strobe is accepted when the FIFO is not full. If the FIFO is full,
//   the strobe is lost and o_DROP is high for that same EMUCLK cycle. o_BUSY
//   is the advisory flow-control signal.
//   Register-file side: o_REG_WR acts as a valid with no ready. o_REG_ADDR and
//   o_REG_DATA are stable for the whole phi1 cycle in which o_REG_WR is high.
//   They keep their last committed values afterwards.
module ika2151_regwr_scheduler #(
  parameter int DEPTH       = 4,
  parameter int BUSY_CYCLES = 32
) (
  input  logic                   i_EMUCLK,
  input  logic                   i_RST,
  input  logic                   i_phi1_NCEN_n,
  input  logic                   i_MRST_n,
  input  logic                   i_CYCLE_31,
  input  logic                   i_WR_STB,
  input  logic                   i_A0,
  input  logic [7:0]             i_DIN,
  output logic                   o_BUSY,
  output logic                   o_REG_WR,
  output logic [7:0]             o_REG_ADDR,
  output logic [7:0]             o_REG_DATA,
  output logic [$clog2(DEPTH):0] o_LEVEL,
  output logic                   o_DROP
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [7:0]    BUSY_LOAD  = 8'(BUSY_CYCLES);

  // Frame-level qualifiers
  logic tick;       // phi1 tick: the only edges the core timing advances on
  logic flush;      // core reset tick: empties the queue, keeps the address
  logic commit;     // frame commit slot
  logic addr_wr;    // host address write taking effect this edge
  logic data_wr;    // host data write taking effect this edge
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;

  // Storage
  logic [7:0]    addr_latch;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic [7:0]    busy_cnt;
  logic          reg_wr;
  logic [7:0]    reg_addr;
  logic [7:0]    reg_data;

  assign tick       = ~i_phi1_NCEN_n;
  assign flush      = tick & ~i_MRST_n;
  assign commit     = tick & i_MRST_n & i_CYCLE_31;

  // A host write that lands on the flush edge is thrown away with the queue.
  assign addr_wr    = i_WR_STB & ~i_A0 & ~flush;
  assign data_wr    = i_WR_STB &  i_A0 & ~flush;

  assign fifo_full  = (level == FULL_LEVEL);
  assign fifo_empty = (level == '0);

  // Fullness and emptiness are judged on the state before this edge.
  // A push into an empty queue therefore cannot be popped on the same edge.
  assign push       = data_wr & ~fifo_full;
  assign pop        = commit & ~fifo_empty;

  assign o_DROP     = data_wr & fifo_full;
  assign o_BUSY     = (busy_cnt != 8'd0) | ~fifo_empty;
  assign o_LEVEL    = level;
  assign o_REG_WR   = reg_wr;
  assign o_REG_ADDR = reg_addr;
  assign o_REG_DATA = reg_data;

  // Address latch. It is cleared only by the hard reset and survives a core reset.
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      addr_latch <= 8'h00;
    end else if (addr_wr) begin
      addr_latch <= i_DIN;
    end
  end

  // Queue storage. Each entry is {address held before the strobe, data}.
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= {addr_latch, i_DIN};
    end
  end

  // Queue pointers and occupancy. Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level <= level + LW'(push) - LW'(pop);
    end
  end

  // Busy hold-off counter. A fresh accepted write reloads it, taking priority over a tick decrement.
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      busy_cnt <= 8'd0;
    end else if (flush) begin
      busy_cnt <= 8'd0;
    end else if (push) begin
      busy_cnt <= BUSY_LOAD;
    end else if (tick && busy_cnt != 8'd0) begin
      busy_cnt <= busy_cnt - 8'd1;
    end
  end

  // Commit stage: register the popped entry and hold the write pulse for exactly one phi1 cycle.
  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      reg_wr   <= 1'b0;
      reg_addr <= 8'h00;
      reg_data <= 8'h00;
    end else if (tick) begin
      reg_wr <= pop;
      if (pop) begin
        reg_addr <= mem[rd_ptr][15:8];
        reg_data <= mem[rd_ptr][7:0];
      end
    end
  end

endmodule

// File: tb/tb_ika2151_regwr_scheduler.sv
`timescale 1ns/1ps
// tb_ika2151_regwr_scheduler
// Directed test of the register-write scheduler. Expected commits
// ({addr, data}) are queued when stimulus is issued. A free-running monitor
// pops one entry each time the write pulse rises and compares against it.
module tb_ika2151_regwr_scheduler;

  localparam int DEPTH       = 4;
  localparam int BUSY_CYCLES = 32;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       phi1_ncen_n;
  logic       mrst_n;
  logic       cycle_31;
  logic       wr_stb;
  logic       a0;
  logic [7:0] din;
  logic       busy;
  logic       reg_wr;
  logic [7:0] reg_addr;
  logic [7:0] reg_data;
  logic [2:0] level;
  logic       drop;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];
  int phase;
  int slot;

  always #5 clk = ~clk;

  ika2151_regwr_scheduler #(
    .DEPTH(DEPTH),
    .BUSY_CYCLES(BUSY_CYCLES)
  ) dut (
    .i_EMUCLK(clk),
    .i_RST(rst),
    .i_phi1_NCEN_n(phi1_ncen_n),
    .i_MRST_n(mrst_n),
    .i_CYCLE_31(cycle_31),
    .i_WR_STB(wr_stb),
    .i_A0(a0),
    .i_DIN(din),
    .o_BUSY(busy),
    .o_REG_WR(reg_wr),
    .o_REG_ADDR(reg_addr),
    .o_REG_DATA(reg_data),
    .o_LEVEL(level),
    .o_DROP(drop)
  );

  // Timing generator model: a phi1 tick every 4 EMUCLKs and 32 slots per frame.
  // Values change 1 ns after each rising edge and apply to the next edge.
  initial begin : timing_gen
    phase       = 0;
    slot        = 0;
    phi1_ncen_n = 1'b1;
    cycle_31    = 1'b0;
    forever begin
      @(posedge clk); #1;
      phase = (phase + 1) % 4;
      if (phase == 3) begin
        phi1_ncen_n = 1'b0;
        cycle_31    = (slot == 31);
        slot        = (slot + 1) % 32;
      end else begin
        phi1_ncen_n = 1'b1;
        cycle_31    = 1'b0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_bound(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // All driver tasks start and end 2 ns after a rising edge.
  // At that point, the timing inputs already show what the next edge will see.
  task automatic write_now(input logic a0v, input logic [7:0] d, output logic dropped);
    a0     = a0v;
    din    = d;
    wr_stb = 1'b1;
    #1;
    dropped = drop;
    @(posedge clk); #2;
    wr_stb = 1'b0;
  endtask

  task automatic write(input logic a0v, input logic [7:0] d, output logic dropped);
    @(posedge clk); #2;
    write_now(a0v, d, dropped);
  endtask

  task automatic wait_tick_ahead();
    int i;
    i = 0;
    @(posedge clk); #2;
    while (phi1_ncen_n !== 1'b0 && i < 16) begin
      @(posedge clk); #2;
      i++;
    end
    if (phi1_ncen_n !== 1'b0) fail_bound("tick_wait");
  endtask

  task automatic wait_frame_start();
    int i;
    i = 0;
    @(posedge clk); #2;
    while (!(phi1_ncen_n === 1'b0 && cycle_31 === 1'b1) && i < 200) begin
      @(posedge clk); #2;
      i++;
    end
    if (!(phi1_ncen_n === 1'b0 && cycle_31 === 1'b1)) fail_bound("frame_wait");
  endtask

  task automatic wait_commit_rise(output int ticks);
    logic prev;
    logic was_tick;
    bit   seen;
    prev  = reg_wr;
    ticks = 0;
    seen  = 0;
    for (int i = 0; i < 300; i++) begin
      was_tick = (phi1_ncen_n == 1'b0);
      @(posedge clk); #2;
      if (was_tick) ticks++;
      if (reg_wr && !prev) begin
        seen = 1;
        break;
      end
      prev = reg_wr;
    end
    if (!seen) fail_bound("commit_wait");
  endtask

  task automatic wait_drain();
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 2000) begin
      @(posedge clk); #2;
      i++;
    end
    if (exp_q.size() != 0) fail_bound("drain_wait");
    repeat (8) @(posedge clk);
    #2;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    logic        prev;
    int          width;
    logic [15:0] e;
    prev  = 1'b0;
    width = 0;
    forever begin
      @(negedge clk);
      if (reg_wr === 1'b1 && prev === 1'b0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_commit: got addr 0x%0h data 0x%0h, expected no commit at %0t",
                   reg_addr, reg_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("commit_addr_data", {reg_addr, reg_data}, e);
        end
        width = 0;
      end
      if (reg_wr === 1'b1) width++;
      if (reg_wr === 1'b0 && prev === 1'b1 && !rst) check("reg_wr_width", width, 4);
      prev = reg_wr;
    end
  end

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 1 ms");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic dr;
    int   t;
    int   commit_t;
    int   fall_t;
    logic prev;
    logic was_tick;

    rst    = 1'b1;
    mrst_n = 1'b1;
    wr_stb = 1'b0;
    a0     = 1'b0;
    din    = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    check("rst_level", level, 0);
    check("rst_busy", busy, 0);
    check("rst_reg_wr", reg_wr, 0);
    check("rst_reg_addr", reg_addr, 8'h00);
    check("rst_reg_data", reg_data, 8'h00);
    check("rst_drop", drop, 0);
    rst = 1'b0;

    // Single write: the data strobe lands on the slot-15 tick.
    // The commit arrives at slot 31, 16 ticks later. BUSY falls at 32 ticks.
    write(1'b0, 8'h20, dr);
    wait_frame_start();
    repeat (16) wait_tick_ahead();
    exp_q.push_back({8'h20, 8'hC7});
    write_now(1'b1, 8'hC7, dr);
    check("single_drop", dr, 0);
    check("single_busy_rise", busy, 1);
    check("single_level", level, 1);
    t        = 0;
    commit_t = -1;
    fall_t   = -1;
    prev     = reg_wr;
    for (int i = 0; i < 400; i++) begin
      was_tick = (phi1_ncen_n == 1'b0);
      @(posedge clk); #2;
      if (was_tick) t++;
      if (reg_wr && !prev && commit_t < 0) commit_t = t;
      prev = reg_wr;
      if (!busy) begin
        fall_t = t;
        break;
      end
    end
    check("single_commit_tick", commit_t, 16);
    check("single_busy_fall_tick", fall_t, 32);
    wait_drain();

    // Burst of five writes into a DEPTH-4 queue.
    // The fifth write is dropped, then four commits follow in consecutive frames.
    write(1'b0, 8'h08, dr);
    wait_frame_start();
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) exp_q.push_back({8'h08, 8'(k)});
      write(1'b1, 8'(k), dr);
      check("burst_drop", dr, (k == 5) ? 1 : 0);
    end
    check("burst_level_full", level, 4);
    check("burst_busy", busy, 1);
    for (int k = 1; k <= 4; k++) begin
      wait_commit_rise(t);
      check("burst_level_count", level, 4 - k);
      if (k > 1) check("burst_frame_spacing", t, 32);
    end
    wait_drain();

    // Address retention across interleaved address and data writes.
    write(1'b0, 8'h10, dr);
    exp_q.push_back({8'h10, 8'hAA});
    write(1'b1, 8'hAA, dr);
    write(1'b0, 8'h11, dr);
    exp_q.push_back({8'h11, 8'hBB});
    write(1'b1, 8'hBB, dr);
    wait_drain();

    // A push and a pop on the same commit edge leave the level unchanged.
    write(1'b0, 8'h30, dr);
    wait_frame_start();
    exp_q.push_back({8'h30, 8'h31});
    write(1'b1, 8'h31, dr);
    exp_q.push_back({8'h30, 8'h32});
    write(1'b1, 8'h32, dr);
    check("simul_level_before", level, 2);
    wait_frame_start();
    exp_q.push_back({8'h30, 8'h33});
    write_now(1'b1, 8'h33, dr);
    check("simul_reg_wr", reg_wr, 1);
    check("simul_level_after", level, 2);
    wait_drain();

    // A push into an empty queue on the commit edge waits one full frame.
    write(1'b0, 8'h40, dr);
    wait_frame_start();
    exp_q.push_back({8'h40, 8'h44});
    write_now(1'b1, 8'h44, dr);
    check("empty_push_level", level, 1);
    check("empty_push_no_wr", reg_wr, 0);
    wait_commit_rise(t);
    check("empty_push_delay", t, 32);
    wait_drain();

    // Core reset flushes queued entries but keeps the address latch.
    write(1'b0, 8'h55, dr);
    wait_frame_start();
    write(1'b1, 8'h01, dr);
    write(1'b1, 8'h02, dr);
    check("flush_level_before", level, 2);
    wait_tick_ahead();
    mrst_n = 1'b0;
    @(posedge clk); #2;
    mrst_n = 1'b1;
    check("flush_level", level, 0);
    check("flush_busy", busy, 0);
    wait_frame_start();
    @(posedge clk); #2;
    check("flush_no_commit", reg_wr, 0);
    exp_q.push_back({8'h55, 8'h77});
    write(1'b1, 8'h77, dr);
    wait_drain();

    // Hard reset in the middle of a stream clears everything without a tick.
    write(1'b0, 8'h66, dr);
    wait_frame_start();
    write(1'b1, 8'h01, dr);
    write(1'b1, 8'h02, dr);
    write(1'b1, 8'h03, dr);
    check("rst_mid_level_before", level, 3);
    rst = 1'b1;
    #1;
    check("rst_mid_level", level, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_reg_wr", reg_wr, 0);
    check("rst_mid_reg_addr", reg_addr, 8'h00);
    check("rst_mid_reg_data", reg_data, 8'h00);
    @(posedge clk); #2;
    rst = 1'b0;
    // The address latch was cleared too, so the next data write goes to 0x00.
    exp_q.push_back({8'h00, 8'h99});
    write(1'b1, 8'h99, dr);
    wait_drain();

    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
